// File: rtl/multi_alarm_bank.sv
// multi_alarm_bank: bank of N hh:mm alarms with per-alarm enable,
// ring/snooze/dismiss sequencing and automatic ring timeout.
// One clock tick is one second; time comes in as binary, the selected
// alarm is shown as BCD digits.
`timescale 1ns/1ps

module multi_alarm_bank #(
  parameter int N_ALARMS       = 4,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5,
  localparam int IDXW          = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk_out_seconds,
  input  logic                reset,
  input  logic [IDXW-1:0]     sel,
  input  logic                Updown,
  input  logic                alarm_count_min,
  input  logic                alarm_count_hours,
  input  logic                en_toggle,
  input  logic                snooze,
  input  logic                dismiss,
  input  logic [5:0]          cur_minutes,
  input  logic [4:0]          cur_hours,
  output logic [3:0]          alarm_minutes_units,
  output logic [2:0]          alarm_minutes_tens,
  output logic [3:0]          alarm_hours_units,
  output logic [1:0]          alarm_hours_tens,
  output logic [N_ALARMS-1:0] alarm_en,
  output logic                ringing,
  output logic                snoozing,
  output logic [IDXW-1:0]     ring_idx
);

  localparam int              CNTW     = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(RING_TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZE
  } state_e;

  // Alarm storage
  logic [5:0]          min_q [N_ALARMS];
  logic [5:0]          min_d [N_ALARMS];
  logic [4:0]          hr_q  [N_ALARMS];
  logic [4:0]          hr_d  [N_ALARMS];
  logic [N_ALARMS-1:0] en_q, en_d;

  // Time-change detection
  logic [10:0] cur_time;
  logic [10:0] prev_time_q;
  logic        prev_valid_q;
  logic        change_evt;

  // Sequencer
  state_e          state_q;
  logic [IDXW-1:0] ring_idx_q;
  logic [CNTW-1:0] cnt_q;
  logic [10:0]     tgt_q;
  logic            ringing_q, snoozing_q;

  logic            sel_ok;
  logic            match_hit;
  logic [IDXW-1:0] match_idx;
  logic            owner_off;
  logic [6:0]      snz_sum;
  logic [5:0]      tgt_min;
  logic [4:0]      tgt_hr;
  logic [5:0]      disp_min;
  logic [4:0]      disp_hr;

  assign sel_ok     = 32'(sel) < N_ALARMS;
  assign cur_time   = {cur_hours, cur_minutes};
  assign change_evt = prev_valid_q && (cur_time != prev_time_q);

  // Next alarm values from the adjust and enable-toggle controls
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    min_d = min_q;
    hr_d  = hr_q;
    en_d  = en_q;
    if (sel_ok) begin
      if (alarm_count_min) begin
        if (Updown) min_d[sel] = (min_q[sel] == 6'd59) ? 6'd0  : min_q[sel] + 6'd1;
        else        min_d[sel] = (min_q[sel] == 6'd0)  ? 6'd59 : min_q[sel] - 6'd1;
      end
      if (alarm_count_hours) begin
        if (Updown) hr_d[sel] = (hr_q[sel] == 5'd23) ? 5'd0  : hr_q[sel] + 5'd1;
        else        hr_d[sel] = (hr_q[sel] == 5'd0)  ? 5'd23 : hr_q[sel] - 5'd1;
      end
      if (en_toggle) en_d[sel] = ~en_q[sel];
    end
  end

  // Alarm registers
  always_ff @(posedge clk_out_seconds or negedge reset) begin
    if (!reset) begin
      // NOTE: this small register file is reset on purpose: every alarm must read 00:00 after reset.
      for (int k = 0; k < N_ALARMS; k++) begin
        min_q[k] <= '0;
        hr_q[k]  <= '0;
      end
      en_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      min_q <= min_d;
      hr_q  <= hr_d;
      en_q  <= en_d;
    end
  end

  // Remember the previous time so only real transitions can trigger a match
  always_ff @(posedge clk_out_seconds or negedge reset) begin
    if (!reset) begin
      prev_time_q  <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_time_q  <= cur_time;
      prev_valid_q <= 1'b1;
    end
  end

  // Lowest-index enabled alarm equal to the current time, on a change event only
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (en_q[k] && (min_q[k] == cur_minutes) && (hr_q[k] == cur_hours)) begin
        match_hit = change_evt;
        match_idx = IDXW'(k);
      end
    end
  end

  // Snooze target: now + SNOOZE_MIN minutes, carrying into hours, wrapping at 24:00
  always_comb begin
    snz_sum = {1'b0, cur_minutes} + 7'(SNOOZE_MIN);
    tgt_min = snz_sum[5:0];
    tgt_hr  = cur_hours;
    if (snz_sum >= 7'd60) begin
      tgt_min = 6'(snz_sum - 7'd60);
      tgt_hr  = (cur_hours == 5'd23) ? 5'd0 : cur_hours + 5'd1;
    end
  end

  // The owning alarm is being switched off this tick
  assign owner_off = en_toggle && sel_ok && (sel == ring_idx_q) && en_q[ring_idx_q];

  // Ring/snooze sequencer with registered outputs
  always_ff @(posedge clk_out_seconds or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ring_idx_q <= '0;
      cnt_q      <= '0;
      tgt_q      <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match_hit) begin
            state_q    <= ST_RINGING;
            ring_idx_q <= match_idx;
            cnt_q      <= '0;
            ringing_q  <= 1'b1;
            snoozing_q <= 1'b0;
          end
        end
        ST_RINGING, ST_SNOOZE: begin
          if (dismiss || owner_off) begin
            state_q    <= ST_IDLE;
            ring_idx_q <= '0;
            cnt_q      <= '0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (match_hit && (match_idx != ring_idx_q)) begin
            state_q    <= ST_RINGING;
            ring_idx_q <= match_idx;
            cnt_q      <= '0;
            ringing_q  <= 1'b1;
            snoozing_q <= 1'b0;
          end else if ((state_q == ST_RINGING) && snooze) begin
            state_q    <= ST_SNOOZE;
            tgt_q      <= {tgt_hr, tgt_min};
            cnt_q      <= '0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b1;
          end else if ((state_q == ST_SNOOZE) && change_evt && (cur_time == tgt_q)) begin
            state_q    <= ST_RINGING;
            cnt_q      <= '0;
            ringing_q  <= 1'b1;
            snoozing_q <= 1'b0;
          end else if (state_q == ST_RINGING) begin
            if (cnt_q == CNT_LAST) begin
              state_q    <= ST_IDLE;
              ring_idx_q <= '0;
              cnt_q      <= '0;
              ringing_q  <= 1'b0;
              snoozing_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ring_idx_q <= '0;
          cnt_q      <= '0;
          ringing_q  <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  // BCD digits of the selected alarm; an out-of-range select shows zeros
  always_comb begin
    disp_min = '0;
    disp_hr  = '0;
    if (sel_ok) begin
      disp_min = min_q[sel];
      disp_hr  = hr_q[sel];
    end
    alarm_minutes_units = 4'(disp_min % 6'd10);
    alarm_minutes_tens  = 3'(disp_min / 6'd10);
    alarm_hours_units   = 4'(disp_hr % 5'd10);
    alarm_hours_tens    = 2'(disp_hr / 5'd10);
  end

  assign alarm_en = en_q;
  assign ringing  = ringing_q;
  assign snoozing = snoozing_q;
  assign ring_idx = ring_idx_q;

endmodule

// File: tb/tb_multi_alarm_bank.sv
// Self-checking bench for multi_alarm_bank: directed scenarios followed by
// randomized stimulus, all compared against a minute-of-day reference model.
`timescale 1ns/1ps

module tb_multi_alarm_bank;

  localparam int N = 4;
  localparam int T = 60;
  localparam int S = 5;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  logic       clk_out_seconds = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sel = '0;
  logic       Updown = 1'b0;
  logic       alarm_count_min = 1'b0;
  logic       alarm_count_hours = 1'b0;
  logic       en_toggle = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic [5:0] cur_minutes = '0;
  logic [4:0] cur_hours = '0;

  logic [3:0]   alarm_minutes_units;
  logic [2:0]   alarm_minutes_tens;
  logic [3:0]   alarm_hours_units;
  logic [1:0]   alarm_hours_tens;
  logic [N-1:0] alarm_en;
  logic         ringing;
  logic         snoozing;
  logic [1:0]   ring_idx;

  multi_alarm_bank #(
    .N_ALARMS      (N),
    .RING_TIMEOUT_S(T),
    .SNOOZE_MIN    (S)
  ) dut (
    .clk_out_seconds    (clk_out_seconds),
    .reset              (reset),
    .sel                (sel),
    .Updown             (Updown),
    .alarm_count_min    (alarm_count_min),
    .alarm_count_hours  (alarm_count_hours),
    .en_toggle          (en_toggle),
    .snooze             (snooze),
    .dismiss            (dismiss),
    .cur_minutes        (cur_minutes),
    .cur_hours          (cur_hours),
    .alarm_minutes_units(alarm_minutes_units),
    .alarm_minutes_tens (alarm_minutes_tens),
    .alarm_hours_units  (alarm_hours_units),
    .alarm_hours_tens   (alarm_hours_tens),
    .alarm_en           (alarm_en),
    .ringing            (ringing),
    .snoozing           (snoozing),
    .ring_idx           (ring_idx)
  );

  always #5 clk_out_seconds = ~clk_out_seconds;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (times as minute-of-day) ----------------
  int m_min [N];
  int m_hr  [N];
  bit m_en  [N];
  int m_state, m_idx, m_cnt, m_tgt, m_prev;
  bit m_valid;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_min[i] = 0;
      m_hr[i]  = 0;
      m_en[i]  = 1'b0;
    end
    m_state = M_IDLE;
    m_idx   = 0;
    m_cnt   = 0;
    m_tgt   = 0;
    m_prev  = 0;
    m_valid = 1'b0;
  endtask

  task automatic model_idle();
    m_state = M_IDLE;
    m_idx   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_ring(input int k);
    m_state = M_RING;
    m_idx   = k;
    m_cnt   = 0;
  endtask

  // One clock edge's worth of behaviour, evaluated from pre-edge model state
  task automatic model_step();
    int cur;
    bit chg;
    int k;
    int s;
    cur = int'(cur_hours) * 60 + int'(cur_minutes);
    chg = m_valid && (cur != m_prev);
    s   = int'(sel);
    k   = -1;
    if (chg) begin
      for (int i = 0; i < N; i++)
        if (k < 0 && m_en[i] && (m_hr[i] * 60 + m_min[i] == cur)) k = i;
    end
    if (m_state == M_IDLE) begin
      if (k >= 0) model_ring(k);
    end else begin
      if (dismiss) model_idle();
      else if (en_toggle && s == m_idx && m_en[m_idx]) model_idle();
      else if (k >= 0 && k != m_idx) model_ring(k);
      else if (m_state == M_RING && snooze) begin
        m_state = M_SNZ;
        m_tgt   = (cur + S) % 1440;
      end else if (m_state == M_SNZ && chg && cur == m_tgt) model_ring(m_idx);
      else if (m_state == M_RING) begin
        m_cnt++;
        if (m_cnt >= T) model_idle();
      end
    end
    if (s < N) begin
      if (alarm_count_min)   m_min[s] = Updown ? (m_min[s] + 1) % 60 : (m_min[s] + 59) % 60;
      if (alarm_count_hours) m_hr[s]  = Updown ? (m_hr[s] + 1) % 24  : (m_hr[s] + 23) % 24;
      if (en_toggle)         m_en[s]  = ~m_en[s];
    end
    m_valid = 1'b1;
    m_prev  = cur;
  endtask

  task automatic check_outputs();
    int s, exp_bcd, obs_bcd, exp_en;
    s = int'(sel);
    exp_bcd = 0;
    if (s < N)
      exp_bcd = (m_hr[s] / 10) * 4096 + (m_hr[s] % 10) * 256 + (m_min[s] / 10) * 16 + (m_min[s] % 10);
    obs_bcd = int'(alarm_hours_tens) * 4096 + int'(alarm_hours_units) * 256
            + int'(alarm_minutes_tens) * 16 + int'(alarm_minutes_units);
    exp_en = 0;
    for (int i = 0; i < N; i++) if (m_en[i]) exp_en += (1 << i);
    check("ringing",  int'(ringing),  int'(m_state == M_RING));
    check("snoozing", int'(snoozing), int'(m_state == M_SNZ));
    check("ring_idx", int'(ring_idx), m_idx);
    check("alarm_en", int'(alarm_en), exp_en);
    check("bcd_hhmm", obs_bcd, exp_bcd);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_out_seconds);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic pulses_off();
    alarm_count_min   = 1'b0;
    alarm_count_hours = 1'b0;
    en_toggle         = 1'b0;
    snooze            = 1'b0;
    dismiss           = 1'b0;
  endtask

  task automatic set_time(input int h, input int m);
    cur_hours   = 5'(h);
    cur_minutes = 6'(m);
  endtask

  task automatic step_time(input int h, input int m);
    set_time(h, m);
    tick();
  endtask

  task automatic set_alarm(input int idx, input int h, input int m);
    int steps;
    sel    = 2'(idx);
    Updown = 1'b1;
    steps  = (m - m_min[idx] + 60) % 60;
    alarm_count_min = 1'b1;
    repeat (steps) tick();
    alarm_count_min = 1'b0;
    steps = (h - m_hr[idx] + 24) % 24;
    alarm_count_hours = 1'b1;
    repeat (steps) tick();
    alarm_count_hours = 1'b0;
  endtask

  task automatic toggle_en(input int idx);
    sel       = 2'(idx);
    en_toggle = 1'b1;
    tick();
    en_toggle = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_ringing",  int'(ringing),  0);
    check("rst_snoozing", int'(snoozing), 0);
    check("rst_ring_idx", int'(ring_idx), 0);
    check("rst_alarm_en", int'(alarm_en), 0);
    check("rst_min_units", int'(alarm_minutes_units), 0);
    check("rst_hr_tens",   int'(alarm_hours_tens), 0);
    check_outputs();
    @(negedge clk_out_seconds);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, t, k;
    model_reset();
    pulses_off();
    #3;
    check_outputs();
    @(negedge clk_out_seconds);
    reset = 1'b1;

    // Adjust: 61 minute increments wrap to 01, then hours down twice to 22
    sel = 2'd2;
    Updown = 1'b1;
    alarm_count_min = 1'b1;
    repeat (61) tick();
    alarm_count_min = 1'b0;
    check("adj_min_units", int'(alarm_minutes_units), 1);
    check("adj_min_tens",  int'(alarm_minutes_tens), 0);
    Updown = 1'b0;
    alarm_count_hours = 1'b1;
    repeat (2) tick();
    alarm_count_hours = 1'b0;
    check("adj_hr_tens",  int'(alarm_hours_tens), 2);
    check("adj_hr_units", int'(alarm_hours_units), 2);

    // Ring and timeout at 07:30
    set_alarm(1, 7, 30);
    toggle_en(1);
    step_time(7, 29);
    step_time(7, 30);
    check("to_ring",  int'(ringing), 1);
    check("to_idx",   int'(ring_idx), 1);
    repeat (T - 1) tick();
    check("to_hold",  int'(ringing), 1);
    tick();
    check("to_expire", int'(ringing), 0);
    repeat (5) tick();
    check("to_no_rering", int'(ringing), 0);

    // Snooze across midnight: 23:58 + 5 -> 00:03
    set_alarm(0, 23, 58);
    toggle_en(0);
    step_time(23, 57);
    step_time(23, 58);
    check("snz_ring", int'(ringing), 1);
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    check("snz_enter", int'(snoozing), 1);
    check("snz_quiet", int'(ringing), 0);
    step_time(23, 59);
    step_time(0, 0);
    step_time(0, 1);
    step_time(0, 2);
    check("snz_wait", int'(snoozing), 1);
    step_time(0, 3);
    check("snz_rering", int'(ringing), 1);
    check("snz_idx",    int'(ring_idx), 0);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    check("snz_dismiss", int'(ringing | snoozing), 0);

    // Simultaneous match: lowest index wins; disabling the owner stops it
    set_alarm(1, 12, 0);
    set_alarm(3, 12, 0);
    toggle_en(3);
    step_time(11, 59);
    step_time(12, 0);
    check("sim_idx",  int'(ring_idx), 1);
    check("sim_ring", int'(ringing), 1);
    toggle_en(1);
    check("sim_owner_off", int'(ringing), 0);
    check("sim_en1", int'(alarm_en[1]), 0);

    // Dismiss beats snooze
    toggle_en(1);
    step_time(11, 59);
    step_time(12, 0);
    check("pri_ring", int'(ringing), 1);
    snooze  = 1'b1;
    dismiss = 1'b1;
    tick();
    pulses_off();
    check("pri_ringing",  int'(ringing), 0);
    check("pri_snoozing", int'(snoozing), 0);

    // Reset mid-ring
    step_time(11, 59);
    step_time(12, 0);
    check("mr_ring", int'(ringing), 1);
    async_reset();
    tick();
    check("mr_first_tick", int'(ringing), 0);
    toggle_en(0);
    step_time(23, 59);
    step_time(0, 0);
    check("mr_ring_again", int'(ringing), 1);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      t = int'(cur_hours) * 60 + int'(cur_minutes);
      r = $urandom_range(0, 99);
      if (r < 45) begin
        // hold time
      end else if (r < 75) begin
        t = (t + 1) % 1440;
      end else if (r < 88) begin
        k = $urandom_range(0, N - 1);
        t = m_hr[k] * 60 + m_min[k];
      end else if (r < 94) begin
        t = m_tgt;
      end else begin
        t = $urandom_range(0, 1439);
      end
      set_time(t / 60, t % 60);
      sel               = 2'($urandom_range(0, 3));
      Updown            = 1'($urandom_range(0, 1));
      alarm_count_min   = ($urandom_range(0, 9) == 0);
      alarm_count_hours = ($urandom_range(0, 9) == 0);
      en_toggle         = ($urandom_range(0, 11) == 0);
      snooze            = ($urandom_range(0, 7) == 0);
      dismiss           = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 699) == 0) async_reset();
      tick();
    end
    pulses_off();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
